aes32_state_ctrl: RTL and testbench
===================================

# aes32_state_ctrl

Control sequencer for the masked 32-bit AES state datapath. It accepts one encrypt or decrypt request at a time and steps through the LOAD, round, final-key and output phases. Each cycle it drives the datapath routing controls, the Sbox input strobe and the round-key index for the key schedule. It contains no shared data, so it is mask-agnostic and shared between all masking orders `d`.

## Interface
Parameters:
- `SB_LAT`, default 4: Sbox pipeline latency in cycles.
  - Legal range is 4 to 8.
  - Any other value is an elaboration error.
  - Each round and each key pass lasts `SB_LAT` cycles.

Ports:
- `clk` in 1: single clock. All flops are clocked on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: a request is present.
- `in_inverse` in 1: request type. 1 = decrypt, 0 = encrypt. Sampled on acceptance.
- `in_ready` out 1: the controller can accept a request.
- `out_valid` out 1: the datapath holds the result.
- `out_ready` in 1: the downstream consumer takes the result.
- `busy` out 1: high from the LOAD cycle until the cycle of result handshake.
- `dp_enable` out 1: shift/load strobe for the state register.
- `dp_init` out 1: selects a parallel plaintext load.
- `dp_en_MC`, `dp_en_loop`, `dp_en_loop_r0`, `dp_en_SB_inverse`, `dp_bypass_MC_inverse`, `dp_en_toSB_inverse` out 1 each: datapath routing selects.
- `sb_in_valid` out 1: the column presented to the Sbox this cycle is live.
- `key_rnd` out 4: round-key index requested from the key schedule.
- `key_col` out 2: column index within the current round.
- `key_inverse` out 1: latched request type, for the key schedule.

## Operation
Every output is registered except `in_ready`. `in_ready` is a decode of the IDLE state.

States: IDLE, LOAD, KINIT, ROUND, KFINAL, DONE. Two counters: `rnd` (4 bits) and `cyc` (0 to `SB_LAT`-1).

- **IDLE**
  - `in_ready`=1; all `dp_*`, `sb_in_valid` and `busy` are 0.
  - `in_valid`&`in_ready` → LOAD, with `key_inverse` latched from `in_inverse`.
- **LOAD** (1 cycle)
  - `dp_init`=1, `dp_enable`=1, `busy`=1.
  - Next state: KINIT if inverse, otherwise ROUND with `rnd`=0.
- **KINIT** (inverse only, `SB_LAT` cycles)
  - `dp_en_loop_r0`=1, `dp_en_loop`=1; `key_rnd`=10.
  - `dp_enable`=1 while `cyc`<4, else 0.
  - Then → ROUND with `rnd`=0.
- **ROUND** (10 rounds × `SB_LAT` cycles)
  - In every cycle with `cyc`<4: `dp_enable`=1, `sb_in_valid`=1, `key_col`=`cyc`. In every cycle with `cyc`≥4: `dp_enable`=0, `sb_in_valid`=0.
  - Forward: `dp_en_MC`=1 when `rnd`≠9; `key_rnd`=`rnd`; loop and inverse selects are 0.
  - Inverse:
    - `dp_en_toSB_inverse`=1, `dp_en_SB_inverse`=1, `dp_en_loop`=1.
    - `dp_bypass_MC_inverse`=1 only when `rnd`=0.
    - `dp_en_MC`=0; `key_rnd`=9−`rnd`.
  - After `rnd`=9 completes: forward → KFINAL, inverse → DONE.
- **KFINAL** (forward only, `SB_LAT` cycles)
  - `dp_en_loop_r0`=1; `key_rnd`=10.
  - `dp_enable` follows the same `cyc`<4 rule.
  - Then → DONE.
- **DONE**
  - `out_valid`=1, `busy`=1, `dp_enable`=0, so the state is frozen.
  - `out_ready`=1 → IDLE.
  - `in_ready` stays 0 until the cycle after the handshake, so there is no back-to-back overlap.

Boundary conditions:
- `in_valid` in any non-IDLE state is ignored.
- `in_inverse` changing after acceptance has no effect.
- If `out_ready` is held low, DONE holds indefinitely and all `dp_*` stay 0.

## Timing
- **Reset** (`rst_n`=0 at an edge) → IDLE at the next cycle, from any state including mid-round. Reset values:
  - `in_ready`=1.
  - `out_valid`, `busy`, all `dp_*`, `sb_in_valid`, `key_inverse` = 0.
  - `key_rnd`=0, `key_col`=0.
- **Latency**, with the accept edge as cycle 0 (LOAD is in cycle 1):
  - Forward: `out_valid` first high in cycle 2+11·`SB_LAT` (46 for `SB_LAT`=4).
  - Inverse: same cycle count (KINIT replaces KFINAL).
- `key_rnd`/`key_col` are valid in the same cycle as the `dp_enable` they accompany.
- `sb_in_valid` asserts exactly 40 times per operation (10 rounds × 4 columns).

## Structure
- **Shared package** (`aes_ctrl_pkg`):
  - state encoding enum (6 values);
  - `NB_ROUNDS`=10;
  - `KEY_RND_LAST`=10;
  - `NB_COLS`=4.
- **Sub-module** `aes_round_counter`: the `rnd`/`cyc` pair, with wrap and terminal-count flags. It is reused by the key-schedule controller.
- The FSM, output decode and handshake stay in the top module.

## Test plan
- **Reset, then forward request** with `SB_LAT`=4:
  - `in_ready` falls the cycle after accept;
  - `dp_init` high in cycle 1 only;
  - `dp_en_MC` high over cycles 2–37 and low over 38–41;
  - `dp_en_loop_r0` high over cycles 42–45;
  - `out_valid` in cycle 46.
- **Inverse request** with `SB_LAT`=4:
  - `key_rnd` reads 10 ×4, then 9 ×4, …, 0 ×4;
  - `dp_bypass_MC_inverse` high exactly in cycles 6–9;
  - `dp_en_toSB_inverse` high over cycles 6–45.
- **`SB_LAT`=6**: each round has 4 `dp_enable` cycles then 2 idle cycles; `out_valid` in cycle 68; `sb_in_valid` count = 40.
- **`out_ready` held low 10 cycles in DONE**:
  - `out_valid` stays high and `dp_enable` stays 0;
  - a new `in_valid` is ignored;
  - accept occurs only after the handshake.
- **`rst_n` low during ROUND cycle 20**: all outputs reach reset values next cycle; a following request completes in 46 cycles.
- **Integration with the datapath at `d`=2**: FIPS-197 key 000102…0f with plaintext 00112233…ff → ciphertext 69c4e0d8…c55a; the inverse run returns the plaintext.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the masked AES-32 control sequencer and its key-schedule peer.
package aes_ctrl_pkg;

  localparam int NB_ROUNDS    = 10;
  localparam int KEY_RND_LAST = 10;
  localparam int NB_COLS      = 4;
  // Wide enough for the largest legal Sbox latency (8 -> cyc 0..7).
  localparam int CYC_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KINIT,
    ST_ROUND,
    ST_KFINAL,
    ST_DONE
  } state_t;

  // Everything the sequencer drives from flops, grouped so one register holds it all.
  typedef struct packed {
    logic       busy;
    logic       out_valid;
    logic       dp_enable;
    logic       dp_init;
    logic       dp_en_mc;
    logic       dp_en_loop;
    logic       dp_en_loop_r0;
    logic       dp_en_sb_inverse;
    logic       dp_bypass_mc_inverse;
    logic       dp_en_tosb_inverse;
    logic       sb_in_valid;
    logic [3:0] key_rnd;
    logic [1:0] key_col;
  } ctrl_out_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round / cycle-within-round counter pair with wrap and terminal-count flags.
// Exposes the values the pair will hold after the next edge so that callers can
// register decodes that line up with the counter itself.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SB_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [3:0]       rnd_next,
  output logic [CYC_W-1:0] cyc_next,
  output logic             cyc_wrap,
  output logic             rnd_tc
);

  logic [3:0]       rnd;
  logic [CYC_W-1:0] cyc;

  assign cyc_wrap = (cyc == CYC_W'(SB_LAT - 1));
  assign rnd_tc   = cyc_wrap && (rnd == 4'(NB_ROUNDS - 1));

  // Next counter values: clear wins over advance; cyc wraps into the next round.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    rnd_next = rnd;
    cyc_next = cyc;
    if (clr) begin
      rnd_next = '0;
      cyc_next = '0;
    end else if (en) begin
      if (cyc_wrap) begin
        cyc_next = '0;
        rnd_next = rnd + 4'd1;
      end else begin
        cyc_next = cyc + CYC_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all flops sample pre-edge values regardless of statement order.
    if (!rst_n) begin
      rnd <= '0;
      cyc <= '0;
    end else begin
      rnd <= rnd_next;
      cyc <= cyc_next;
    end
  end

endmodule

// File: rtl/aes32_state_ctrl.sv
// Control sequencer for the masked 32-bit AES state datapath: one encrypt or
// decrypt at a time through LOAD, key-init / rounds / final-key and DONE phases.
module aes32_state_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SB_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_inverse,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       dp_enable,
  output logic       dp_init,
  output logic       dp_en_MC,
  output logic       dp_en_loop,
  output logic       dp_en_loop_r0,
  output logic       dp_en_SB_inverse,
  output logic       dp_bypass_MC_inverse,
  output logic       dp_en_toSB_inverse,
  output logic       sb_in_valid,
  output logic [3:0] key_rnd,
  output logic [1:0] key_col,
  output logic       key_inverse
);

  if (SB_LAT < 4 || SB_LAT > 8) begin : g_bad_sb_lat
    $error("aes32_state_ctrl: SB_LAT must lie in 4..8");
  end

  state_t           state, state_next;
  ctrl_out_t        out_q, out_d;
  logic             cnt_clr, cnt_en;
  logic [3:0]       rnd_next;
  logic [CYC_W-1:0] cyc_next;
  logic             cyc_wrap, rnd_tc;
  logic             col_live;

  aes_round_counter #(.SB_LAT(SB_LAT)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .rnd_next (rnd_next),
    .cyc_next (cyc_next),
    .cyc_wrap (cyc_wrap),
    .rnd_tc   (rnd_tc)
  );

  assign in_ready = (state == ST_IDLE);

  // Next-state logic; the counter restarts at every phase boundary.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE:  if (in_valid) state_next = ST_LOAD;
      ST_LOAD:  state_next = key_inverse ? ST_KINIT : ST_ROUND;
      ST_KINIT: begin
        cnt_clr = !cyc_wrap;
        cnt_en  = 1'b1;
        cnt_clr = cyc_wrap;
        if (cyc_wrap) state_next = ST_ROUND;
      end
      ST_ROUND: begin
        cnt_en  = 1'b1;
        cnt_clr = rnd_tc;
        if (rnd_tc) state_next = key_inverse ? ST_DONE : ST_KFINAL;
      end
      ST_KFINAL: begin
        cnt_en  = 1'b1;
        cnt_clr = cyc_wrap;
        if (cyc_wrap) state_next = ST_DONE;
      end
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so registered outputs align with it.
  always_comb begin
    out_d    = '0;
    col_live = (cyc_next < CYC_W'(NB_COLS));
    case (state_next)
      ST_LOAD: begin
        out_d.busy      = 1'b1;
        out_d.dp_init   = 1'b1;
        out_d.dp_enable = 1'b1;
      end
      ST_KINIT: begin
        out_d.busy          = 1'b1;
        out_d.dp_enable     = col_live;
        out_d.dp_en_loop_r0 = 1'b1;
        out_d.dp_en_loop    = 1'b1;
        out_d.key_rnd       = 4'(KEY_RND_LAST);
        out_d.key_col       = col_live ? cyc_next[1:0] : 2'd0;
      end
      ST_ROUND: begin
        out_d.busy        = 1'b1;
        out_d.dp_enable   = col_live;
        out_d.sb_in_valid = col_live;
        out_d.key_col     = col_live ? cyc_next[1:0] : 2'd0;
        if (key_inverse) begin
          out_d.dp_en_tosb_inverse   = 1'b1;
          out_d.dp_en_sb_inverse     = 1'b1;
          out_d.dp_en_loop           = 1'b1;
          out_d.dp_bypass_mc_inverse = (rnd_next == 4'd0);
          out_d.key_rnd              = 4'(NB_ROUNDS - 1) - rnd_next;
        end else begin
          out_d.dp_en_mc = (rnd_next != 4'(NB_ROUNDS - 1));
          out_d.key_rnd  = rnd_next;
        end
      end
      ST_KFINAL: begin
        out_d.busy          = 1'b1;
        out_d.dp_enable     = col_live;
        out_d.dp_en_loop_r0 = 1'b1;
        out_d.key_rnd       = 4'(KEY_RND_LAST);
        out_d.key_col       = col_live ? cyc_next[1:0] : 2'd0;
      end
      ST_DONE: begin
        out_d.busy      = 1'b1;
        out_d.out_valid = 1'b1;
      end
      default: out_d = '0;
    endcase
  end

  // State, output and request-type registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_q       <= '0;
      key_inverse <= 1'b0;
    end else begin
      state <= state_next;
      out_q <= out_d;
      if (state == ST_IDLE && in_valid) key_inverse <= in_inverse;
    end
  end

  assign busy                 = out_q.busy;
  assign out_valid            = out_q.out_valid;
  assign dp_enable            = out_q.dp_enable;
  assign dp_init              = out_q.dp_init;
  assign dp_en_MC             = out_q.dp_en_mc;
  assign dp_en_loop           = out_q.dp_en_loop;
  assign dp_en_loop_r0        = out_q.dp_en_loop_r0;
  assign dp_en_SB_inverse     = out_q.dp_en_sb_inverse;
  assign dp_bypass_MC_inverse = out_q.dp_bypass_mc_inverse;
  assign dp_en_toSB_inverse   = out_q.dp_en_tosb_inverse;
  assign sb_in_valid          = out_q.sb_in_valid;
  assign key_rnd              = out_q.key_rnd;
  assign key_col              = out_q.key_col;

endmodule

// File: tb/tb_aes32_state_ctrl.sv
// Self-checking bench for aes32_state_ctrl at SB_LAT=4 and SB_LAT=6.
// Expected per-cycle output traces are built from the phase schedule of an operation.
module tb_aes32_state_ctrl;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic       dp_enable;
    logic       dp_init;
    logic       en_mc;
    logic       en_loop;
    logic       en_loop_r0;
    logic       en_sb_inv;
    logic       bypass_mc_inv;
    logic       en_tosb_inv;
    logic       sb_in_valid;
    logic       key_inverse;
    logic [3:0] key_rnd;
    logic [1:0] key_col;
  } obs_t;

  typedef struct packed {
    obs_t val;
    obs_t care;
  } exp_t;

  typedef struct {
    bit inv;
    bit sel6;
    int hold;
    int abort_at;
    int exp_lat;
    int exp_sbv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_inverse, out_ready, sel6;
  wire  iv4 = in_valid & ~sel6;
  wire  iv6 = in_valid & sel6;
  wire  or4 = out_ready & ~sel6;
  wire  or6 = out_ready & sel6;
  wire  obs_t o4, o6;
  obs_t obs;
  exp_t trace[$];
  int   n_vec = 0;
  int   n_err = 0;

  assign obs = sel6 ? o6 : o4;

  always #5 clk = ~clk;

  aes32_state_ctrl #(.SB_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_inverse(in_inverse),
    .in_ready(o4.in_ready), .out_valid(o4.out_valid), .out_ready(or4), .busy(o4.busy),
    .dp_enable(o4.dp_enable), .dp_init(o4.dp_init), .dp_en_MC(o4.en_mc),
    .dp_en_loop(o4.en_loop), .dp_en_loop_r0(o4.en_loop_r0), .dp_en_SB_inverse(o4.en_sb_inv),
    .dp_bypass_MC_inverse(o4.bypass_mc_inv), .dp_en_toSB_inverse(o4.en_tosb_inv),
    .sb_in_valid(o4.sb_in_valid), .key_rnd(o4.key_rnd), .key_col(o4.key_col),
    .key_inverse(o4.key_inverse)
  );

  aes32_state_ctrl #(.SB_LAT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_inverse(in_inverse),
    .in_ready(o6.in_ready), .out_valid(o6.out_valid), .out_ready(or6), .busy(o6.busy),
    .dp_enable(o6.dp_enable), .dp_init(o6.dp_init), .dp_en_MC(o6.en_mc),
    .dp_en_loop(o6.en_loop), .dp_en_loop_r0(o6.en_loop_r0), .dp_en_SB_inverse(o6.en_sb_inv),
    .dp_bypass_MC_inverse(o6.bypass_mc_inv), .dp_en_toSB_inverse(o6.en_tosb_inv),
    .sb_in_valid(o6.sb_in_valid), .key_rnd(o6.key_rnd), .key_col(o6.key_col),
    .key_inverse(o6.key_inverse)
  );

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (((obs ^ e.val) & e.care) != '0) begin
      n_err++;
      $display("FAIL %s @%0t: got %h required %h (care %h)", name, $time, obs, e.val, e.care);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, req);
    end
  endtask

  // Post-reset values: every output fully specified.
  function automatic exp_t rst_exp();
    exp_t e;
    e.val          = '0;
    e.val.in_ready = 1'b1;
    e.care         = '1;
    return e;
  endfunction

  // Idle after an operation: key outputs and latched type are not constrained.
  function automatic exp_t idle_exp();
    exp_t e;
    e = rst_exp();
    e.care.key_rnd     = '0;
    e.care.key_col     = '0;
    e.care.key_inverse = 1'b0;
    return e;
  endfunction

  // Common frame for a cycle of an active operation.
  function automatic exp_t busy_exp(input bit inv);
    exp_t e;
    e.val              = '0;
    e.val.busy         = 1'b1;
    e.val.key_inverse  = inv;
    e.care             = '1;
    e.care.key_rnd     = '0;
    e.care.key_col     = '0;
    return e;
  endfunction

  // Cycles 1..N of an operation: LOAD, optional key pass, 10 rounds, optional key pass, DONE.
  task automatic build_trace(input bit inv, input int lat);
    exp_t e;
    trace.delete();
    e = busy_exp(inv);
    e.val.dp_init   = 1'b1;
    e.val.dp_enable = 1'b1;
    trace.push_back(e);
    for (int p = 0; p < 12; p++) begin
      bit is_key;
      is_key = (p == 0) || (p == 11);
      if ((p == 0 && !inv) || (p == 11 && inv)) continue;
      for (int c = 0; c < lat; c++) begin
        e = busy_exp(inv);
        e.val.dp_enable = (c < 4);
        e.care.key_rnd  = '1;
        if (is_key) begin
          e.val.en_loop_r0 = 1'b1;
          e.val.en_loop    = inv;
          e.val.key_rnd    = 4'd10;
        end else begin
          e.val.sb_in_valid = (c < 4);
          if (c < 4) begin
            e.care.key_col = '1;
            e.val.key_col  = 2'(c);
          end
          if (inv) begin
            e.val.en_tosb_inv   = 1'b1;
            e.val.en_sb_inv     = 1'b1;
            e.val.en_loop       = 1'b1;
            e.val.bypass_mc_inv = (p == 1);
            e.val.key_rnd       = 4'(10 - p);
          end else begin
            e.val.en_mc   = (p != 10);
            e.val.key_rnd = 4'(p - 1);
          end
        end
        trace.push_back(e);
      end
    end
    e = busy_exp(inv);
    e.val.out_valid = 1'b1;
    trace.push_back(e);
  endtask

  // One request: accept, per-cycle trace check with noisy inputs, DONE hold, handshake.
  task automatic run_op(input vec_t v);
    int first_ov;
    int sbv;
    exp_t done_e;
    sel6 = v.sel6;
    @(negedge clk);
    check("accept_ready", idle_exp());
    in_valid   = 1'b1;
    in_inverse = v.inv;
    out_ready  = 1'($urandom_range(0, 1));
    build_trace(v.inv, v.sel6 ? 6 : 4);
    done_e   = trace[trace.size() - 1];
    first_ov = -1;
    sbv      = 0;
    for (int k = 0; k < trace.size(); k++) begin
      @(negedge clk);
      if (obs.out_valid && first_ov < 0) first_ov = k + 1;
      if (obs.sb_in_valid) sbv++;
      check($sformatf("%s_cyc%0d", v.inv ? "inv" : "fwd", k + 1), trace[k]);
      in_valid   = 1'($urandom_range(0, 1));
      in_inverse = 1'($urandom_range(0, 1));
      out_ready  = (k == trace.size() - 1) ? (v.hold == 0) : 1'($urandom_range(0, 1));
      if (v.abort_at == k + 1) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_round", rst_exp());
        rst_n    = 1'b1;
        in_valid = 1'b0;
        return;
      end
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("done_hold", done_e);
      in_valid   = 1'b1;
      in_inverse = ~v.inv;
      out_ready  = (h == v.hold - 1);
    end
    @(negedge clk);
    check("after_handshake", idle_exp());
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_int("out_valid_latency", first_ov, v.exp_lat);
    check_int("sb_in_valid_count", sbv, v.exp_sbv);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t rv;
    vecs[0] = '{inv: 1'b0, sel6: 1'b0, hold: 0,  abort_at: 0,  exp_lat: 46, exp_sbv: 40};
    vecs[1] = '{inv: 1'b1, sel6: 1'b0, hold: 0,  abort_at: 0,  exp_lat: 46, exp_sbv: 40};
    vecs[2] = '{inv: 1'b0, sel6: 1'b1, hold: 0,  abort_at: 0,  exp_lat: 68, exp_sbv: 40};
    vecs[3] = '{inv: 1'b1, sel6: 1'b1, hold: 3,  abort_at: 0,  exp_lat: 68, exp_sbv: 40};
    vecs[4] = '{inv: 1'b0, sel6: 1'b0, hold: 10, abort_at: 0,  exp_lat: 46, exp_sbv: 40};
    vecs[5] = '{inv: 1'b0, sel6: 1'b0, hold: 0,  abort_at: 20, exp_lat: 46, exp_sbv: 40};
    vecs[6] = '{inv: 1'b0, sel6: 1'b0, hold: 1,  abort_at: 0,  exp_lat: 46, exp_sbv: 40};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_inverse = 1'b0;
    out_ready  = 1'b0;
    sel6       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_lat4", rst_exp());
    sel6 = 1'b1;
    #1;
    check("reset_lat6", rst_exp());
    sel6  = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      rv.inv      = 1'($urandom_range(0, 1));
      rv.sel6     = 1'($urandom_range(0, 1));
      rv.hold     = int'($urandom_range(0, 5));
      rv.abort_at = 0;
      rv.exp_lat  = 2 + 11 * (rv.sel6 ? 6 : 4);
      rv.exp_sbv  = 40;
      run_op(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
